// File: rtl/alu_seq_param.sv
// Parametrised handshaked ALU: bit-wise, add/sub and shift ops finish in one cycle,
// unsigned multiply runs shift-add over WIDTH cycles; results are held until consumed.
module alu_seq_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           SEL,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   O,
    output logic                 CARRY,
    output logic                 ZERO,
    output logic                 OVF
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH-1:0] o_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               ovf_reg;

    logic               accept;
    logic [WIDTH-1:0]   res;
    logic               res_carry;
    logic               res_ovf;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl_ext;
    logic [2*WIDTH-1:0] shr_ext;
    logic [CW-1:0]      amt;

    // Single-cycle result path, evaluated on the live operands at the accept edge.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        amt       = B[CW-1:0];
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        // Widened shifts expose the last bit shifted out at the W boundary.
        shl_ext   = {{WIDTH{1'b0}}, A} << amt;
        shr_ext   = {A, {WIDTH{1'b0}}} >> amt;
        case (SEL)
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SHL: begin
                res       = shl_ext[WIDTH-1:0];
                res_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res       = shr_ext[2*WIDTH-1:WIDTH];
                res_carry = shr_ext[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !rst;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = (SEL == OP_MUL) ? S_MULT : S_HOLD;
                end
            end
            S_MULT: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = !rst;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            o_reg     <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (SEL == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            o_reg     <= {{WIDTH{1'b0}}, res};
                            carry_reg <= res_carry;
                            zero_reg  <= (res == '0);
                            ovf_reg   <= res_ovf;
                        end
                    end
                end
                S_MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        o_reg     <= acc_next;
                        carry_reg <= |acc_next[2*WIDTH-1:WIDTH];
                        zero_reg  <= (acc_next == '0);
                        ovf_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs read as zero for as long as reset is held, not just after its edge.
    always_comb begin
        O     = rst ? '0 : o_reg;
        CARRY = rst ? 1'b0 : carry_reg;
        ZERO  = rst ? 1'b0 : zero_reg;
        OVF   = rst ? 1'b0 : ovf_reg;
    end

endmodule
